// File: rtl/if_loader_pkg.sv
// Shared types and flag-bit positions for the IF row loader.
package if_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEEK,
        ST_LOAD,
        ST_DONE
    } state_t;

    function automatic int start_bit_pos(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int end_bit_pos(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/sp_ring_ptr.sv
// Scratchpad ring write pointer with occupancy counter and full flag.
module sp_ring_ptr #(
    parameter int SP_DEPTH = 16,
    parameter int ADDR_W   = $clog2(SP_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic              consume,
    output logic [ADDR_W-1:0] waddr,
    output logic              full
);

    localparam logic [ADDR_W:0] OCC_FULL = (ADDR_W + 1)'(SP_DEPTH);

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_occ;
    logic              w_consume;

    // A consume with nothing stored is dropped rather than underflowing.
    assign w_consume = consume && (r_occ != '0);
    assign waddr     = r_ptr;
    assign full      = (r_occ == OCC_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_occ <= '0;
        end else begin
            if (wen) begin
                r_ptr <= r_ptr + 1'b1;
            end
            case ({wen, w_consume})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/if_row_loader.sv
// Multi-row IF loader: seeks row-start flags in the input buffer and streams
// each row into the ring-addressed scratchpad under occupancy back-pressure.
module if_row_loader
    import if_loader_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int SP_DEPTH = 16,
    parameter int ADDR_W   = $clog2(SP_DEPTH),
    parameter int ROWS_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROWS_W-1:0] row_count,
    input  logic              buf_empty,
    input  logic [DATA_W+1:0] buf_rdata,
    output logic              buf_ren,
    output logic              sp_wen,
    output logic [ADDR_W-1:0] sp_waddr,
    output logic [DATA_W-1:0] sp_wdata,
    input  logic              sp_consume,
    output logic              row_valid,
    output logic [ADDR_W-1:0] row_start_ptr,
    output logic [ADDR_W-1:0] row_end_ptr,
    output logic [ROWS_W-1:0] rows_loaded,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int START_BIT_POS = start_bit_pos(DATA_W);
    localparam int END_BIT_POS   = end_bit_pos(DATA_W);

    state_t            r_state;
    logic [ROWS_W-1:0] r_target;
    logic [ROWS_W-1:0] r_rows;
    logic [ADDR_W-1:0] r_cur_start;
    logic [ADDR_W-1:0] r_start_ptr;
    logic [ADDR_W-1:0] r_end_ptr;
    logic              r_row_valid;
    logic              r_done;
    logic              r_err;

    logic              w_full;
    logic [ADDR_W-1:0] w_ptr;
    logic              w_sbit;
    logic              w_ebit;
    logic              w_seek;
    logic              w_load;
    logic              w_avail;
    logic              w_discard;
    logic              w_wen;
    logic              w_ren;
    logic [ADDR_W-1:0] w_row_start;
    logic [ROWS_W-1:0] w_rows_next;

    assign w_sbit    = buf_rdata[START_BIT_POS];
    assign w_ebit    = buf_rdata[END_BIT_POS];
    assign w_seek    = (r_state == ST_SEEK);
    assign w_load    = (r_state == ST_LOAD);
    // Reset gates the handshake so no word is lost during the reset cycle.
    assign w_avail   = (w_seek || w_load) && !buf_empty && !rst;
    assign w_discard = w_seek && !w_sbit;
    assign w_wen     = w_avail && !w_full && !w_discard;
    assign w_ren     = w_avail && (w_discard || !w_full);

    assign w_row_start = w_sbit ? w_ptr : r_cur_start;
    assign w_rows_next = r_rows + 1'b1;

    assign buf_ren       = w_ren;
    assign sp_wen        = w_wen;
    assign sp_waddr      = w_ptr;
    assign sp_wdata      = buf_rdata[DATA_W-1:0];
    assign row_valid     = r_row_valid;
    assign row_start_ptr = r_start_ptr;
    assign row_end_ptr   = r_end_ptr;
    assign rows_loaded   = r_rows;
    assign busy          = (r_state != ST_IDLE);
    assign done          = r_done;
    assign err           = r_err;

    sp_ring_ptr #(
        .SP_DEPTH (SP_DEPTH),
        .ADDR_W   (ADDR_W)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .wen     (w_wen),
        .consume (sp_consume),
        .waddr   (w_ptr),
        .full    (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_target    <= '0;
            r_rows      <= '0;
            r_cur_start <= '0;
            r_start_ptr <= '0;
            r_end_ptr   <= '0;
            r_row_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_row_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_target <= row_count;
                        r_rows   <= '0;
                        r_err    <= 1'b0;
                        if (row_count == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_SEEK;
                        end
                    end
                end
                ST_SEEK, ST_LOAD: begin
                    if (w_wen) begin
                        if (w_sbit) begin
                            r_cur_start <= w_ptr;
                        end
                        if (w_load && w_sbit) begin
                            r_err <= 1'b1;
                        end
                        if (w_ebit) begin
                            r_start_ptr <= w_row_start;
                            r_end_ptr   <= w_ptr;
                            r_row_valid <= 1'b1;
                            r_rows      <= w_rows_next;
                            if (w_rows_next == r_target) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_SEEK;
                            end
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_row_loader.sv
// Directed self-checking bench for if_row_loader (DATA_W=8, SP_DEPTH=8).
module tb_if_row_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] row_count;
    logic       buf_empty;
    logic [9:0] buf_rdata;
    logic       buf_ren;
    logic       sp_wen;
    logic [2:0] sp_waddr;
    logic [7:0] sp_wdata;
    logic       sp_consume;
    logic       row_valid;
    logic [2:0] row_start_ptr;
    logic [2:0] row_end_ptr;
    logic [7:0] rows_loaded;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Show-ahead input buffer model
    logic [9:0] mem [0:127];
    logic [6:0] head = '0;
    logic [6:0] tail = '0;
    logic       flush = 1'b0;

    assign buf_empty = (head == tail);
    assign buf_rdata = mem[head];

    always @(posedge clk) begin
        if (flush) head <= tail;
        else if (buf_ren) head <= head + 7'd1;
    end

    // Event logs sampled mid-cycle
    logic [2:0] wa [0:127];
    logic [7:0] wd [0:127];
    logic [2:0] rv_s [0:31];
    logic [2:0] rv_e [0:31];
    logic [7:0] rv_n [0:31];
    logic       rv_d [0:31];
    int wr_cnt = 0;
    int pop_cnt = 0;
    int rv_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (sp_wen) begin
            wa[wr_cnt[6:0]] <= sp_waddr;
            wd[wr_cnt[6:0]] <= sp_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (buf_ren) pop_cnt <= pop_cnt + 1;
        if (row_valid) begin
            rv_s[rv_cnt[4:0]] <= row_start_ptr;
            rv_e[rv_cnt[4:0]] <= row_end_ptr;
            rv_n[rv_cnt[4:0]] <= rows_loaded;
            rv_d[rv_cnt[4:0]] <= done;
            rv_cnt <= rv_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    if_row_loader #(
        .DATA_W   (8),
        .SP_DEPTH (8),
        .ADDR_W   (3),
        .ROWS_W   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .row_count     (row_count),
        .buf_empty     (buf_empty),
        .buf_rdata     (buf_rdata),
        .buf_ren       (buf_ren),
        .sp_wen        (sp_wen),
        .sp_waddr      (sp_waddr),
        .sp_wdata      (sp_wdata),
        .sp_consume    (sp_consume),
        .row_valid     (row_valid),
        .row_start_ptr (row_start_ptr),
        .row_end_ptr   (row_end_ptr),
        .rows_loaded   (rows_loaded),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [9:0] word(input logic s, input logic e, input logic [7:0] d);
        return {s, e, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] w);
        mem[tail] = w;
        tail = tail + 7'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b1; start = 1'b0; sp_consume = 1'b0;
        tick(2);
        rst = 1'b0; flush = 1'b0;
        tick(1);
    endtask

    task automatic start_xfer(input logic [7:0] n);
        start = 1'b1; row_count = n;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int maxc, output bit timed_out);
        int n = 0;
        while (done_cnt == base && n < maxc) begin
            @(negedge clk);
            n++;
        end
        tick(1);
        timed_out = (done_cnt == base);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sp_consume = 1'b0; row_count = '0; flush = 1'b1;
        tick(3);
        @(negedge clk);
        checks++; if (buf_ren !== 1'b0) begin errors++; $display("FAIL reset_buf_ren got %0b exp 0", buf_ren); end
        checks++; if (sp_wen !== 1'b0) begin errors++; $display("FAIL reset_sp_wen got %0b exp 0", sp_wen); end
        checks++; if (sp_waddr !== 3'd0) begin errors++; $display("FAIL reset_sp_waddr got %0d exp 0", sp_waddr); end
        checks++; if ({row_valid, busy, done, err} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {row_valid, busy, done, err}); end
        checks++; if ({row_start_ptr, row_end_ptr, rows_loaded} !== 14'd0) begin errors++; $display("FAIL reset_ptrs got %0h exp 0", {row_start_ptr, row_end_ptr, rows_loaded}); end
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0;
        tick(1);
    endtask

    task automatic test_zero_rows();
        int pb;
        do_reset();
        push(word(1'b1, 1'b1, 8'h01));
        pb = pop_cnt;
        start_xfer(8'd0);
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_pulse got %0b exp 1", done); end
        @(negedge clk);
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL zero_done_end got %b exp 00", {done, busy}); end
        tick(3);
        checks++; if (pop_cnt - pb !== 0) begin errors++; $display("FAIL zero_pops got %0d exp 0", pop_cnt - pb); end
    endtask

    task automatic test_garbage_rows();
        int wb, pb, rb, db;
        bit to;
        logic [7:0] exp_d [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
        do_reset();
        wb = wr_cnt; pb = pop_cnt; rb = rv_cnt; db = done_cnt;
        push(word(1'b0, 1'b0, 8'h11));
        push(word(1'b1, 1'b0, 8'hA0));
        push(word(1'b0, 1'b0, 8'hA1));
        push(word(1'b0, 1'b1, 8'hA2));
        push(word(1'b1, 1'b1, 8'hB0));
        start_xfer(8'd2);
        wait_done(db, 40, to);
        tick(2);
        checks++; if (to) begin errors++; $display("FAIL garbage_timeout got timeout exp done"); end
        checks++; if (wr_cnt - wb !== 4) begin errors++; $display("FAIL garbage_writes got %0d exp 4", wr_cnt - wb); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wa[wb+i] !== 3'(i) || wd[wb+i] !== exp_d[i]) begin
                errors++; $display("FAIL garbage_write%0d got %0d/%0h exp %0d/%0h", i, wa[wb+i], wd[wb+i], i, exp_d[i]);
            end
        end
        checks++; if (pop_cnt - pb !== 5) begin errors++; $display("FAIL garbage_pops got %0d exp 5", pop_cnt - pb); end
        checks++; if (rv_cnt - rb !== 2) begin errors++; $display("FAIL garbage_rows got %0d exp 2", rv_cnt - rb); end
        checks++; if ({rv_s[rb], rv_e[rb], rv_n[rb], rv_d[rb]} !== {3'd0, 3'd2, 8'd1, 1'b0}) begin
            errors++; $display("FAIL garbage_row0 got s%0d e%0d n%0d d%0b exp s0 e2 n1 d0", rv_s[rb], rv_e[rb], rv_n[rb], rv_d[rb]);
        end
        checks++; if ({rv_s[rb+1], rv_e[rb+1], rv_n[rb+1], rv_d[rb+1]} !== {3'd3, 3'd3, 8'd2, 1'b1}) begin
            errors++; $display("FAIL garbage_row1 got s%0d e%0d n%0d d%0b exp s3 e3 n2 d1", rv_s[rb+1], rv_e[rb+1], rv_n[rb+1], rv_d[rb+1]);
        end
        checks++; if ({rows_loaded, busy, err} !== {8'd2, 1'b0, 1'b0}) begin
            errors++; $display("FAIL garbage_final got rows%0d busy%0b err%0b exp rows2 busy0 err0", rows_loaded, busy, err);
        end
    endtask

    task automatic test_backpressure();
        int wb, rb, db;
        bit to;
        do_reset();
        wb = wr_cnt; rb = rv_cnt; db = done_cnt;
        push(word(1'b1, 1'b0, 8'hC0));
        for (int i = 1; i < 9; i++) push(word(1'b0, 1'b0, 8'hC0 + 8'(i)));
        push(word(1'b0, 1'b1, 8'hC9));
        start_xfer(8'd1);
        tick(20);
        @(negedge clk);
        checks++; if (wr_cnt - wb !== 8) begin errors++; $display("FAIL bp_writes_full got %0d exp 8", wr_cnt - wb); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (wa[wb+i] !== 3'(i) || wd[wb+i] !== 8'hC0 + 8'(i)) begin
                errors++; $display("FAIL bp_write%0d got %0d/%0h exp %0d/%0h", i, wa[wb+i], wd[wb+i], i, 8'hC0 + 8'(i));
            end
        end
        checks++; if ({buf_ren, busy} !== 2'b01) begin errors++; $display("FAIL bp_stall got ren%0b busy%0b exp ren0 busy1", buf_ren, busy); end
        @(posedge clk); #1;
        sp_consume = 1'b1; tick(1); sp_consume = 1'b0;
        tick(4);
        checks++; if (wr_cnt - wb !== 9) begin errors++; $display("FAIL bp_one_more got %0d exp 9", wr_cnt - wb); end
        checks++; if (wa[wb+8] !== 3'd0 || wd[wb+8] !== 8'hC8) begin errors++; $display("FAIL bp_wrap_write got %0d/%0h exp 0/c8", wa[wb+8], wd[wb+8]); end
        sp_consume = 1'b1; tick(1); sp_consume = 1'b0;
        wait_done(db, 20, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout got timeout exp done"); end
        checks++; if (wr_cnt - wb !== 10 || wa[wb+9] !== 3'd1 || wd[wb+9] !== 8'hC9) begin
            errors++; $display("FAIL bp_last_write got n%0d %0d/%0h exp n10 1/c9", wr_cnt - wb, wa[wb+9], wd[wb+9]);
        end
        checks++; if (rv_cnt - rb !== 1 || rv_s[rb] !== 3'd0 || rv_e[rb] !== 3'd1) begin
            errors++; $display("FAIL bp_row got n%0d s%0d e%0d exp n1 s0 e1", rv_cnt - rb, rv_s[rb], rv_e[rb]);
        end
    endtask

    // Continues from the backpressure state: occupancy 8, pointer 2, idle.
    task automatic test_full_write_consume();
        int db;
        bit to;
        db = done_cnt;
        push(word(1'b1, 1'b0, 8'h50));
        push(word(1'b0, 1'b1, 8'h51));
        start_xfer(8'd1);
        tick(3);
        @(negedge clk);
        checks++; if ({buf_ren, sp_wen} !== 2'b00) begin errors++; $display("FAIL full_stall got %b exp 00", {buf_ren, sp_wen}); end
        @(posedge clk); #1; sp_consume = 1'b1;
        @(negedge clk);
        checks++; if (sp_wen !== 1'b0) begin errors++; $display("FAIL full_consume_same_cycle got wen %0b exp 0", sp_wen); end
        @(posedge clk); #1; sp_consume = 1'b0;
        @(negedge clk);
        checks++; if ({sp_wen, sp_waddr, sp_wdata} !== {1'b1, 3'd2, 8'h50}) begin
            errors++; $display("FAIL full_after_consume got wen%0b %0d/%0h exp wen1 2/50", sp_wen, sp_waddr, sp_wdata);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (sp_wen !== 1'b0) begin errors++; $display("FAIL full_again got wen %0b exp 0", sp_wen); end
        @(posedge clk); #1; sp_consume = 1'b1; tick(1); sp_consume = 1'b0;
        wait_done(db, 20, to);
        checks++; if (to || rv_s[rv_cnt-1] !== 3'd2 || rv_e[rv_cnt-1] !== 3'd3) begin
            errors++; $display("FAIL full_row got to%0b s%0d e%0d exp to0 s2 e3", to, rv_s[rv_cnt-1], rv_e[rv_cnt-1]);
        end
    endtask

    task automatic test_occ5_write_consume();
        int wb;
        do_reset();
        wb = wr_cnt;
        push(word(1'b1, 1'b0, 8'h60));
        for (int i = 1; i < 4; i++) push(word(1'b0, 1'b0, 8'h60 + 8'(i)));
        push(word(1'b0, 1'b1, 8'h64));
        start_xfer(8'd2);
        tick(10);
        push(word(1'b1, 1'b0, 8'h70));
        sp_consume = 1'b1;
        @(negedge clk);
        checks++; if ({sp_wen, sp_waddr} !== {1'b1, 3'd5}) begin errors++; $display("FAIL occ5_write got wen%0b a%0d exp wen1 a5", sp_wen, sp_waddr); end
        @(posedge clk); #1; sp_consume = 1'b0;
        for (int i = 1; i < 6; i++) push(word(1'b0, 1'b0, 8'h70 + 8'(i)));
        tick(10);
        @(negedge clk);
        checks++; if (wr_cnt - wb !== 9) begin errors++; $display("FAIL occ5_capacity got %0d exp 9", wr_cnt - wb); end
        checks++; if (wa[wb+6] !== 3'd6 || wa[wb+7] !== 3'd7 || wa[wb+8] !== 3'd0) begin
            errors++; $display("FAIL occ5_addrs got %0d %0d %0d exp 6 7 0", wa[wb+6], wa[wb+7], wa[wb+8]);
        end
        checks++; if ({buf_ren, busy, rows_loaded} !== {1'b0, 1'b1, 8'd1}) begin
            errors++; $display("FAIL occ5_stall got ren%0b busy%0b rows%0d exp ren0 busy1 rows1", buf_ren, busy, rows_loaded);
        end
    endtask

    // Continues from the occupancy test: stalled mid-LOAD with words pending.
    task automatic test_rst_mid_load();
        int wb, db;
        bit to;
        @(posedge clk); #1; rst = 1'b1;
        tick(1); rst = 1'b0;
        @(negedge clk);
        checks++; if ({busy, buf_ren, sp_wen, row_valid, done, err} !== 6'b0) begin
            errors++; $display("FAIL rst_flags got %b exp 000000", {busy, buf_ren, sp_wen, row_valid, done, err});
        end
        checks++; if ({sp_waddr, row_start_ptr, row_end_ptr, rows_loaded} !== 17'd0) begin
            errors++; $display("FAIL rst_ptrs got a%0d s%0d e%0d n%0d exp 0 0 0 0", sp_waddr, row_start_ptr, row_end_ptr, rows_loaded);
        end
        @(posedge clk); #1; flush = 1'b1; tick(1); flush = 1'b0;
        wb = wr_cnt; db = done_cnt;
        push(word(1'b1, 1'b1, 8'h90));
        start_xfer(8'd1);
        wait_done(db, 20, to);
        checks++; if (to || wr_cnt - wb !== 1 || wa[wb] !== 3'd0 || wd[wb] !== 8'h90) begin
            errors++; $display("FAIL rst_restart got to%0b n%0d %0d/%0h exp to0 n1 0/90", to, wr_cnt - wb, wa[wb], wd[wb]);
        end
    endtask

    task automatic test_malformed();
        int wb, db;
        bit to;
        do_reset();
        wb = wr_cnt; db = done_cnt;
        push(word(1'b1, 1'b0, 8'h10));
        push(word(1'b0, 1'b0, 8'h11));
        push(word(1'b1, 1'b0, 8'h20));
        push(word(1'b0, 1'b1, 8'h21));
        start_xfer(8'd1);
        wait_done(db, 20, to);
        checks++; if (to || err !== 1'b1) begin errors++; $display("FAIL malformed_err got to%0b err%0b exp to0 err1", to, err); end
        checks++; if (rv_s[rv_cnt-1] !== 3'd2 || rv_e[rv_cnt-1] !== 3'd3) begin
            errors++; $display("FAIL malformed_row got s%0d e%0d exp s2 e3", rv_s[rv_cnt-1], rv_e[rv_cnt-1]);
        end
        push(word(1'b1, 1'b0, 8'h30));
        for (int i = 1; i < 4; i++) push(word(1'b0, 1'b0, 8'h30 + 8'(i)));
        push(word(1'b0, 1'b1, 8'h34));
        start_xfer(8'd1);
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL malformed_err_clear got %0b exp 0", err); end
        tick(12);
        @(negedge clk);
        checks++; if (wr_cnt - wb !== 8 || wa[wb+4] !== 3'd4 || wa[wb+7] !== 3'd7) begin
            errors++; $display("FAIL malformed_occ4 got n%0d first%0d last%0d exp n8 4 7", wr_cnt - wb, wa[wb+4], wa[wb+7]);
        end
        checks++; if ({buf_ren, busy} !== 2'b01) begin errors++; $display("FAIL malformed_stall got %b exp 01", {buf_ren, busy}); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; row_count = '0; sp_consume = 1'b0;
        test_reset();
        test_zero_rows();
        test_garbage_rows();
        test_backpressure();
        test_full_write_consume();
        test_occ5_write_consume();
        test_rst_mid_load();
        test_malformed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
